// File: rtl/pc_target_table.sv
// pc_target_table: run-time programmable branch-target table (absolute or PC-relative entries).
// Revision: 1.0
`default_nettype none

module pc_target_table #(
  parameter int D           = 10,
  parameter int A           = 4,
  parameter bit REL_DEFAULT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         wr_rel,
  input  logic         lk_req,
  input  logic [A-1:0] lk_addr,
  input  logic [D-1:0] pc,
  output logic         busy,
  output logic         lk_ack,
  output logic [D-1:0] target,
  output logic         miss
);

  localparam int         c_DEPTH    = 2**A;
  localparam logic [A-1:0] c_CNT_LAST = '1;
  localparam logic [0:0] c_S_INIT   = 1'b0;
  localparam logic [0:0] c_S_READY  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [A-1:0]       r_cnt;
  logic [D-1:0]       r_data [c_DEPTH];
  logic [c_DEPTH-1:0] r_rel;
  logic [c_DEPTH-1:0] r_written;
  logic               r_ack;
  logic [D-1:0]       r_target;
  logic               r_miss;

  logic               w_ready;
  logic               w_bypass;
  logic [D-1:0]       w_sel_data;
  logic               w_sel_rel;
  logic [D-1:0]       w_target;
  logic               w_miss;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_S_INIT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: READY is terminal until reset
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == c_S_INIT && r_cnt == c_CNT_LAST) w_state_nxt = c_S_READY;
  end

  // Output decode
  always_comb begin
    w_ready = (r_state == c_S_READY);
    busy    = ~w_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_cnt <= '0;
    else if (!w_ready) r_cnt <= r_cnt + 1'b1;
  end

  // Table contents need no reset: the sweep clears every entry before READY.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_data[r_cnt] <= '0;
      r_rel[r_cnt]  <= REL_DEFAULT;
    end else if (wr_en) begin
      r_data[wr_addr] <= wr_data;
      r_rel[wr_addr]  <= wr_rel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_written          <= '0;
    else if (w_ready && wr_en) r_written[wr_addr] <= 1'b1;
  end

  // Same-index write on the lookup edge is forwarded to the result.
  always_comb begin
    w_bypass   = wr_en && (wr_addr == lk_addr);
    w_sel_data = w_bypass ? wr_data : r_data[lk_addr];
    w_sel_rel  = w_bypass ? wr_rel  : r_rel[lk_addr];
    w_target   = w_sel_rel ? (pc + w_sel_data) : w_sel_data;
    w_miss     = ~(w_bypass | r_written[lk_addr]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ack    <= 1'b0;
      r_target <= '0;
      r_miss   <= 1'b0;
    end else begin
      r_ack <= w_ready && lk_req;
      if (w_ready && lk_req) begin
        r_target <= w_target;
        r_miss   <= w_miss;
      end
    end
  end

  assign lk_ack = r_ack;
  assign target = r_target;
  assign miss   = r_miss;

endmodule

`default_nettype wire

// File: tb/tb_pc_target_table.sv
// tb_pc_target_table: vector table, corner sequences and randomized model check for pc_target_table.
// Revision: 1.0
`default_nettype none

module tb_pc_target_table;

  localparam int D     = 10;
  localparam int A     = 4;
  localparam int DEPTH = 16;
  localparam int NVEC  = 14;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_en = 1'b0;
  logic [A-1:0] wr_addr = '0;
  logic [D-1:0] wr_data = '0;
  logic         wr_rel = 1'b0;
  logic         lk_req = 1'b0;
  logic [A-1:0] lk_addr = '0;
  logic [D-1:0] pc = '0;
  logic         busy;
  logic         lk_ack;
  logic [D-1:0] target;
  logic         miss;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain arrays of what each entry holds.
  int m_data [DEPTH];
  bit m_rel  [DEPTH];
  bit m_wr   [DEPTH];
  int e_target;
  bit e_miss;

  typedef struct {
    bit we; int wa; int wd; bit wrel;
    bit req; int la; int p;
    bit ack; int tgt; bit mis;
  } vec_t;
  vec_t vecs [NVEC];

  pc_target_table #(.D(D), .A(A), .REL_DEFAULT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rel(wr_rel),
    .lk_req(lk_req), .lk_addr(lk_addr), .pc(pc),
    .busy(busy), .lk_ack(lk_ack), .target(target), .miss(miss)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = 0;
      m_rel[i]  = 1'b0;
      m_wr[i]   = 1'b0;
    end
    e_target = 0;
    e_miss   = 1'b0;
  endtask

  // One clock: drive inputs, advance past the edge, optionally compare with the model.
  task automatic cycle(input bit we, input int wa, input int wd, input bit wrel,
                       input bit req, input int la, input int p, input bit do_check);
    int  d;
    bit  r;
    bit  byp;
    wr_en   = we;
    wr_addr = A'(wa);
    wr_data = D'(wd);
    wr_rel  = wrel;
    lk_req  = req;
    lk_addr = A'(la);
    pc      = D'(p);
    if (req) begin
      byp = we && (wa == la);
      d   = byp ? wd : m_data[la];
      r   = byp ? wrel : m_rel[la];
      e_target = r ? ((p + d) % 1024) : d;
      e_miss   = !(byp || m_wr[la]);
    end
    @(posedge clk);
    if (we) begin
      m_data[wa] = wd;
      m_rel[wa]  = wrel;
      m_wr[wa]   = 1'b1;
    end
    #1;
    if (do_check) begin
      check("rnd_ack", lk_ack, req);
      check("rnd_target", target, e_target);
      check("rnd_miss", miss, e_miss);
    end
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    lk_req = 1'b0;
  endtask

  // Counts clocks until busy falls; expects exactly 2**A and no ack meanwhile.
  task automatic wait_sweep(input string name);
    int n;
    bit saw_ack;
    n = 0;
    saw_ack = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (lk_ack !== 1'b0) saw_ack = 1'b1;
    end
    check({name, "_len"}, n, DEPTH);
    check({name, "_noack"}, saw_ack, 0);
  endtask

  initial begin
    vecs[0]  = '{1, 3, 68, 0,    0, 0, 0,      0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,     1, 3, 200,    1, 68, 0};
    vecs[2]  = '{0, 0, 0, 0,     1, 9, 200,    1, 0, 1};
    vecs[3]  = '{1, 5, 'h3FF, 1, 0, 0, 0,      0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0,     1, 5, 4,      1, 3, 0};
    vecs[5]  = '{1, 6, 20, 1,    0, 0, 0,      0, 3, 0};
    vecs[6]  = '{0, 0, 0, 0,     1, 6, 1020,   1, 16, 0};
    vecs[7]  = '{1, 7, 95, 0,    1, 7, 0,      1, 95, 0};
    vecs[8]  = '{0, 0, 0, 0,     1, 3, 0,      1, 68, 0};
    vecs[9]  = '{0, 0, 0, 0,     1, 5, 4,      1, 3, 0};
    vecs[10] = '{0, 0, 0, 0,     1, 3, 7,      1, 68, 0};
    vecs[11] = '{0, 0, 0, 0,     1, 6, 1020,   1, 16, 0};
    vecs[12] = '{0, 0, 0, 0,     0, 0, 0,      0, 16, 0};
    vecs[13] = '{1, 9, 'h155, 1, 1, 2, 50,     1, 0, 1};

    model_reset();

    // Reset values, then sweep with lk_req held high
    #2;
    check("rst_busy", busy, 1);
    check("rst_ack", lk_ack, 0);
    check("rst_target", target, 0);
    check("rst_miss", miss, 0);
    lk_req  = 1'b1;
    lk_addr = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_sweep("sweep1");
    idle();

    for (int i = 0; i < NVEC; i++) begin
      cycle(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].wrel,
            vecs[i].req, vecs[i].la, vecs[i].p, 1'b0);
      check($sformatf("vec%0d_ack", i), lk_ack, vecs[i].ack);
      check($sformatf("vec%0d_target", i), target, vecs[i].tgt);
      check($sformatf("vec%0d_miss", i), miss, vecs[i].mis);
    end
    idle();

    // Asynchronous reset while an ack is showing
    cycle(0, 0, 0, 0, 1, 3, 0, 1'b0);
    check("pre_rst_ack", lk_ack, 1);
    check("pre_rst_target", target, 68);
    #2;
    reset = 1'b1;
    #1;
    check("arst_ack", lk_ack, 0);
    check("arst_target", target, 0);
    check("arst_busy", busy, 1);
    check("arst_miss", miss, 0);
    idle();
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Asynchronous reset mid-sweep, sweep restarts from index 0
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midsweep_busy", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_sweep("sweep2");

    model_reset();
    cycle(0, 0, 0, 0, 1, 3, 123, 1'b1);
    check("post_rst_idx3_miss", miss, 1);
    idle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom % 2), int'($urandom % 16), int'($urandom % 1024), 1'($urandom % 2),
            1'($urandom % 4 != 0), int'($urandom % 16), int'($urandom % 1024), 1'b1);
    end
    idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
